// File: rtl/key_debouncer.sv
// Key/switch conditioner: 2-FF sync, polarity fix, debounce, then press/release/long/repeat pulses.
// Level and events appear STABLE_CYCLES+2 edges after a clean raw change; no backpressure, every output is registered.
module key_debouncer #(
  parameter int WIDTH         = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] rpt,
  output logic             any_press
);

  localparam int DW       = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DW-1:0]    STABLE_LAST = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0]    LONG_LAST   = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]    REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [HW-1:0]    HOLD_SAT    = {HW{1'b1}};
  localparam logic [WIDTH-1:0] IDLE_RAW    = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0]         sync1_q, sync1_d;
  logic [WIDTH-1:0]         sync2_q, sync2_d;
  logic [WIDTH-1:0]         synced;
  logic [WIDTH-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [WIDTH-1:0][HW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]         phase_q, phase_d;
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0]         release_q, release_d;
  logic [WIDTH-1:0]         long_q, long_d;
  logic [WIDTH-1:0]         rpt_q, rpt_d;
  logic                     any_press_q, any_press_d;

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    synced    = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    deb_cnt_d = '0;
    hold_d    = hold_q;
    phase_d   = phase_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    rpt_d     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Counter only runs while the synced value disagrees with the accepted level.
      if (synced[i] != level_q[i]) begin
        if (deb_cnt_q[i] == STABLE_LAST) begin
          level_d[i]   = synced[i];
          press_d[i]   = synced[i];
          release_d[i] = ~synced[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end

      if (!level_q[i] || release_d[i]) begin
        hold_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (!phase_q[i]) begin
        if (hold_q[i] == LONG_LAST) begin
          long_d[i]  = 1'b1;
          hold_d[i]  = '0;
          phase_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end else if (REPEAT_CYCLES > 0) begin
        if (hold_q[i] == REPEAT_LAST) begin
          rpt_d[i]  = 1'b1;
          hold_d[i] = '0;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end else if (hold_q[i] != HOLD_SAT) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= IDLE_RAW;
      sync2_q     <= IDLE_RAW;
      deb_cnt_q   <= '0;
      hold_q      <= '0;
      phase_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      rpt_q       <= '0;
      any_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_q      <= hold_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      rpt_q       <= rpt_d;
      any_press_q <= any_press_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign rpt           = rpt_q;
  assign any_press     = any_press_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized and directed key stimulus against a timestamp-based reference model, checked through a scoreboard queue.
module tb_key_debouncer;
  localparam int W  = 4;
  localparam int ST = 4;
  localparam int LG = 10;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '1;
  logic [W-1:0] level, press, release_pulse, long_press, rpt;
  logic         any_press;

  key_debouncer #(
    .WIDTH(W), .ACTIVE_LOW(1), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst(rst), .raw(raw), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .rpt(rpt), .any_press(any_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] lp;
    logic [W-1:0] rpt;
    logic         any;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference: each pin sample reaches the debouncer two edges later; a level flips after
  // ST consecutive disagreeing samples; hold events are derived from the press timestamp.
  bit [W-1:0] dl[$];
  int         run[W];
  bit         lvl[W];
  int         press_t[W];
  int         t = 0;

  always @(posedge clk) begin
    obs_t       e;
    bit [W-1:0] v;
    int         el;
    e = '0;
    t++;
    if (rst) begin
      dl.delete();
      dl.push_back('0);
      dl.push_back('0);
      for (int i = 0; i < W; i++) begin
        run[i]     = 0;
        lvl[i]     = 1'b0;
        press_t[i] = 0;
      end
    end else begin
      v = dl.pop_front();
      dl.push_back(~raw);
      for (int i = 0; i < W; i++) begin
        if (v[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == ST) begin
            lvl[i] = v[i];
            run[i] = 0;
            if (v[i]) begin
              e.press[i] = 1'b1;
              press_t[i] = t;
            end else begin
              e.rel[i] = 1'b1;
            end
          end
        end else begin
          run[i] = 0;
        end
        if (lvl[i] && !e.press[i]) begin
          el = t - press_t[i];
          if (el == LG) e.lp[i] = 1'b1;
          if (RP > 0 && el > LG && ((el - LG) % RP) == 0) e.rpt[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < W; i++) e.level[i] = lvl[i];
    e.any = |e.press;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t a, x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = '{level, press, release_pulse, long_press, rpt, any_press};
      compared++;
      if (a !== x) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b lp=%b rpt=%b any=%b, want lvl=%b prs=%b rel=%b lp=%b rpt=%b any=%b",
                 t, a.level, a.press, a.rel, a.lp, a.rpt, a.any,
                 x.level, x.press, x.rel, x.lp, x.rpt, x.any);
      end
    end
  end

  task automatic step(input logic [W-1:0] r, input int n);
    raw = r;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] r;
    int           n;
    rst = 1'b1;
    raw = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step(4'hF, 10);
    step(4'hE, 12);
    step(4'hF, 10);

    for (int k = 0; k < 5; k++) begin
      step(4'hD, 2);
      step(4'hF, 2);
    end
    step(4'hF, 10);

    step(4'hB, 40);
    step(4'hF, 12);

    step(4'h7, 6);
    step(4'hF, 8);
    step(4'h7, 20);
    step(4'hF, 10);

    step(4'hD, 20);
    step(4'hC, 4);
    rst = 1'b1;
    step(4'hC, 1);
    rst = 1'b0;
    step(4'hD, 15);
    step(4'hF, 10);

    step(4'h0, 8);
    step(4'hF, 10);

    repeat (300) begin
      r = raw;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 2) == 0) r[i] = ~r[i];
      n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(4, 40);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        step(r, 1);
        rst = 1'b0;
        n = (n > 1) ? n - 1 : 1;
      end
      step(r, n);
    end
    step(4'hF, 12);

    @(negedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
